// File: rtl/exe_hazard_ctrl.sv
// EXE-stage hazard controller: operand forwarding selects, load-use bubble
// insertion, multi-cycle flush sequencing after redirects, saturating stats.

module exe_fwd_sel (
  input  logic [4:0] src_i,
  input  logic [4:0] mem_regaddr_i,
  input  logic       mem_wb_en_i,
  input  logic [4:0] wb_regaddr_i,
  input  logic       wb_wb_en_i,
  output logic [1:0] sel_o
);
  always_comb begin
    sel_o = 2'b00;
    // the younger MEM result wins over WB when both match
    if (mem_wb_en_i && mem_regaddr_i != 5'd0 && mem_regaddr_i == src_i)
      sel_o = 2'b01;
    else if (wb_wb_en_i && wb_regaddr_i != 5'd0 && wb_regaddr_i == src_i)
      sel_o = 2'b10;
  end
endmodule

module exe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [4:0]       ex_rs_i,
  input  logic [4:0]       ex_rt_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic [4:0]       mem_regaddr_i,
  input  logic             mem_wb_en_i,
  input  logic [4:0]       wb_regaddr_i,
  input  logic             wb_wb_en_i,
  input  logic [4:0]       ex_regaddr_i,
  input  logic             ex_is_load_i,
  input  logic             redirect_i,
  output logic [1:0]       for_a_o,
  output logic [1:0]       for_b_o,
  output logic             stall_o,
  output logic             bubble_o,
  output logic             flush_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  localparam int NUM_OPS = 2;

  typedef enum logic [1:0] {RUN = 2'd0, LDSTALL = 2'd1, FLUSH = 2'd2} state_e;

  // FLUSH cycles still to go, counting the current one
  localparam logic [2:0] RELOAD = 3'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             hz, stall_c, flush_c;

  logic [NUM_OPS-1:0][4:0] op_src;
  logic [NUM_OPS-1:0][1:0] op_sel;

  assign op_src = {ex_rt_i, ex_rs_i};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
    exe_fwd_sel u_fwd (
      .src_i         (op_src[g]),
      .mem_regaddr_i (mem_regaddr_i),
      .mem_wb_en_i   (mem_wb_en_i),
      .wb_regaddr_i  (wb_regaddr_i),
      .wb_wb_en_i    (wb_wb_en_i),
      .sel_o         (op_sel[g])
    );
  end

  assign hz = ex_is_load_i && ex_regaddr_i != 5'd0 &&
              (ex_regaddr_i == id_rs_i || (id_uses_rt_i && ex_regaddr_i == id_rt_i));

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q     <= RUN;
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    // a single-cycle flush never needs the FLUSH state
    if (redirect_i) begin
      state_d = (RELOAD != 3'd0) ? FLUSH : RUN;
      fcnt_d  = RELOAD;
    end else begin
      unique case (state_q)
        RUN:     if (hz) state_d = LDSTALL;
        LDSTALL: state_d = RUN;
        FLUSH: begin
          if (fcnt_q <= 3'd1) begin
            state_d = RUN;
            fcnt_d  = '0;
          end else begin
            fcnt_d  = fcnt_q - 3'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    flush_c     = redirect_i || state_q == FLUSH;
    stall_c     = state_q == RUN && hz && !flush_c;
    stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, (stall_c && !(&stall_cnt_q))};
    flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, (flush_c && !(&flush_cnt_q))};
  end

  always_comb begin
    for_a_o     = reset_i ? op_sel[0] : 2'b00;
    for_b_o     = reset_i ? op_sel[1] : 2'b00;
    flush_o     = reset_i && flush_c;
    stall_o     = reset_i && stall_c;
    bubble_o    = reset_i && stall_c;
    busy_o      = reset_i && state_q != RUN;
    stall_cnt_o = reset_i ? stall_cnt_q : '0;
    flush_cnt_o = reset_i ? flush_cnt_q : '0;
  end
endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Directed bench for exe_hazard_ctrl; a CNT_W=4 copy shares the stimulus to
// exercise counter saturation.

module tb_exe_hazard_ctrl;
  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] ex_rs, ex_rt, id_rs, id_rt, mem_regaddr, wb_regaddr, ex_regaddr;
  logic       id_uses_rt, mem_wb_en, wb_wb_en, ex_is_load, redirect;
  logic [1:0] for_a, for_b, s_for_a, s_for_b;
  logic       stall, bubble, flush, busy, s_stall, s_bubble, s_flush, s_busy;
  logic [15:0] stall_cnt, flush_cnt;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  exe_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clock_i(clock), .reset_i(reset), .ex_rs_i(ex_rs), .ex_rt_i(ex_rt),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
    .mem_regaddr_i(mem_regaddr), .mem_wb_en_i(mem_wb_en),
    .wb_regaddr_i(wb_regaddr), .wb_wb_en_i(wb_wb_en),
    .ex_regaddr_i(ex_regaddr), .ex_is_load_i(ex_is_load), .redirect_i(redirect),
    .for_a_o(for_a), .for_b_o(for_b), .stall_o(stall), .bubble_o(bubble),
    .flush_o(flush), .busy_o(busy), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  exe_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut_sat (
    .clock_i(clock), .reset_i(reset), .ex_rs_i(ex_rs), .ex_rt_i(ex_rt),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
    .mem_regaddr_i(mem_regaddr), .mem_wb_en_i(mem_wb_en),
    .wb_regaddr_i(wb_regaddr), .wb_wb_en_i(wb_wb_en),
    .ex_regaddr_i(ex_regaddr), .ex_is_load_i(ex_is_load), .redirect_i(redirect),
    .for_a_o(s_for_a), .for_b_o(s_for_b), .stall_o(s_stall), .bubble_o(s_bubble),
    .flush_o(s_flush), .busy_o(s_busy), .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs are then changed and outputs sampled off-edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ex_rs = 0; ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    mem_regaddr = 0; mem_wb_en = 0; wb_regaddr = 0; wb_wb_en = 0;
    ex_regaddr = 0; ex_is_load = 0; redirect = 0;
  endtask

  task automatic set_hz();
    ex_is_load = 1; ex_regaddr = 8; id_rs = 8;
  endtask

  initial begin
    idle();
    // reset with redirect, hazard and forwarding matches all active
    reset = 0; redirect = 1; set_hz();
    ex_rs = 5; mem_regaddr = 5; mem_wb_en = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_flush", flush, 0);
      chk("rst_stall", stall, 0);
      chk("rst_bubble", bubble, 0);
      chk("rst_for_a", for_a, 0);
      chk("rst_busy", busy, 0);
      tick();
    end
    idle(); reset = 1; #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_stall_cnt", stall_cnt, 0);
    chk("post_rst_flush_cnt", flush_cnt, 0);
    chk("post_rst_flush", flush, 0);
    tick();
    chk("post_rst_busy2", busy, 0);

    // forwarding priority
    ex_rs = 5; ex_rt = 5; mem_regaddr = 5; mem_wb_en = 1; wb_regaddr = 5; wb_wb_en = 1; #1;
    chk("fwd_a_mem", for_a, 1);
    chk("fwd_b_mem", for_b, 1);
    mem_wb_en = 0; #1;
    chk("fwd_a_wb", for_a, 2);
    chk("fwd_b_wb", for_b, 2);
    ex_rs = 0; mem_regaddr = 0; mem_wb_en = 1; wb_regaddr = 0; #1;
    chk("fwd_a_r0", for_a, 0);
    ex_rt = 7; wb_regaddr = 7; #1;
    chk("fwd_b_wb_only", for_b, 2);
    chk("fwd_a_split", for_a, 0);
    idle(); tick();

    // load-use via rs
    set_hz(); #1;
    chk("lu_stall", stall, 1);
    chk("lu_bubble", bubble, 1);
    chk("lu_busy0", busy, 0);
    tick();
    chk("ld_stall", stall, 0);
    chk("ld_bubble", bubble, 0);
    chk("ld_busy", busy, 1);
    chk("ld_stall_cnt", stall_cnt, 1);
    idle(); tick();
    chk("ld_back_run", busy, 0);
    chk("ld_stall_cnt2", stall_cnt, 1);

    // rt match only counts when rt is a source
    ex_is_load = 1; ex_regaddr = 8; id_rs = 3; id_rt = 8; id_uses_rt = 0; #1;
    chk("lu_rt_unused", stall, 0);
    id_uses_rt = 1; #1;
    chk("lu_rt_used", stall, 1);
    ex_regaddr = 0; id_rs = 0; id_rt = 0; #1;
    chk("lu_r0", stall, 0);
    idle(); tick();
    chk("lu_cnt_hold", stall_cnt, 1);

    // isolated redirect: two flush cycles
    redirect = 1; #1;
    chk("fl_c0", flush, 1);
    chk("fl_c0_busy", busy, 0);
    tick(); redirect = 0; #1;
    chk("fl_c1", flush, 1);
    chk("fl_c1_busy", busy, 1);
    chk("fl_cnt1", flush_cnt, 1);
    tick();
    chk("fl_done", flush, 0);
    chk("fl_done_busy", busy, 0);
    chk("fl_cnt2", flush_cnt, 2);

    // second redirect inside FLUSH extends to three cycles
    redirect = 1; tick();
    chk("fx_c1", flush, 1);
    tick(); redirect = 0; #1;
    chk("fx_c2", flush, 1);
    chk("fx_c2_busy", busy, 1);
    tick();
    chk("fx_done", flush, 0);
    chk("fx_cnt", flush_cnt, 5);

    // redirect beats a simultaneous load-use hazard
    redirect = 1; set_hz(); #1;
    chk("sim_flush", flush, 1);
    chk("sim_stall", stall, 0);
    chk("sim_bubble", bubble, 0);
    tick(); idle(); #1;
    chk("sim_flush_c1", flush, 1);
    tick();
    chk("sim_stall_cnt", stall_cnt, 1);
    chk("sim_flush_cnt", flush_cnt, 7);

    // reset in the middle of FLUSH
    redirect = 1; tick(); redirect = 0; reset = 0; #1;
    chk("rmid_flush", flush, 0);
    chk("rmid_busy", busy, 0);
    tick(); reset = 1; #1;
    chk("rmid_after_flush", flush, 0);
    chk("rmid_after_busy", busy, 0);
    chk("rmid_flush_cnt", flush_cnt, 0);
    chk("rmid_stall_cnt", stall_cnt, 0);

    // 20 load-use episodes: wide counter reaches 20, 4-bit copy pins at 15
    for (int i = 0; i < 20; i++) begin
      set_hz(); tick();
      idle(); tick();
    end
    chk("sat_wide", stall_cnt, 20);
    chk("sat_narrow", s_stall_cnt, 15);
    chk("sat_narrow_flush", s_flush_cnt, 0);
    chk("sat_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
